pipelinemul: RTL
================

Name: pipelinemul

Overview:
- Pipelined shift-add multiplier: the inverse of the pipelined restoring divider.
- Reconstructs dividend = quotient*divisor + remainder, one quotient bit per stage, one result per clock.
- Used downstream of the divider as a self-check and recomposition path.
- Also flags whether the reconstructed value fits the dividend width and whether remainder < divisor.

Parameters:
- QUOTLEN, 16, quotient width (= divider DIVIDENDLEN); also the number of pipeline stages
- DIVISORLEN, 8, divisor and remainder width
- PRODLEN (localparam), QUOTLEN+DIVISORLEN, accumulator/product width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies quotient/divisor/remainder this cycle
- stall  input  1  global hold; when 1 no pipeline register updates
- quotient  input  QUOTLEN  multiplier operand
- divisor  input  DIVISORLEN  multiplicand
- remainder  input  DIVISORLEN  addend
- out_valid  output  1  product/flags valid
- product  output  PRODLEN  quotient*divisor+remainder
- fits  output  1  product[PRODLEN-1:QUOTLEN]==0
- rem_ok  output  1  remainder < divisor for this item (0 when divisor==0)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Structure:
  - QUOTLEN registered stages, s = 0..QUOTLEN-1.
  - Each stage register holds: valid bit, accumulator[PRODLEN], divisor, remaining quotient bits, rem_ok.
- Stage 0 computes:
  - acc0 = zero-extended remainder + (quotient[0] ? divisor : 0)
  - rem_ok = (remainder < divisor)
- Stage s>0 computes:
  - acc_s = acc_(s-1) + (q_(s-1)[s] ? divisor<<s : 0)
  - divisor and rem_ok pass through unchanged.
- Widths: all adds are PRODLEN bits, unsigned. Overflow is impossible because (2^Q-1)(2^D-1)+(2^D-1) < 2^(Q+D). No saturation logic.
- Register update (pipeline advances):
  - When stall=0, every stage register loads from its predecessor.
  - Stage 0 loads valid=in_valid.
  - Data registers may load unconditionally. Valid bits gate the outputs.
- Stall:
  - When stall=1, all stage registers, including valid bits, hold.
  - in_valid is ignored; no item is accepted and none is lost.
  - Outputs hold steady.
- Latency and throughput:
  - An item is accepted on a rising edge with in_valid=1 and stall=0.
  - Its result appears on the outputs after exactly QUOTLEN non-stalled rising edges, counting the acceptance edge.
  - Throughput is 1 item/cycle. Back-to-back items never interfere.
- Outputs are driven directly from the last stage registers (no combinational path from inputs):
  - out_valid = last stage valid; product = last stage accumulator.
  - fits is combinational from the registered product.
- Bubbles: when out_valid=0, product/fits/rem_ok are don't-care, but must be deterministic (whatever the registers hold).
- Reset:
  - At a reset edge, all valid bits, accumulators, divisor and quotient copies, and rem_ok clear to 0.
  - After reset: out_valid=0, product=0, fits=1, rem_ok=0.
  - reset overrides stall.
  - Reset mid-operation discards every in-flight item. The first item accepted after reset emerges QUOTLEN edges later with no stale data.
- Simultaneous reset and in_valid: reset wins; the item is not accepted.
- divisor==0: product=remainder, rem_ok=0.

Test Plan:
- Nominal (Q=16, D=8): quotient=0x1B46, divisor=0x07, remainder=0x05, single pulse -> exactly 16 edges later out_valid=1 for one cycle, product=0x00BEEF, fits=1, rem_ok=1.
- Maximum operands: quotient=0xFFFF, divisor=0xFF, remainder=0xFE -> product=0xFEFFFF, fits=0, rem_ok=1.
- Divide-by-zero case: quotient=0x0000, divisor=0x00, remainder=0x00 -> product=0x000000, fits=1, rem_ok=0.
- Streaming: 100 consecutive random items, in_valid held high -> out_valid continuous from edge 16. Each product matches the scoreboard value q*d+r, in order.
- Stall: stall=1 for 5 cycles while item 0x1B46/0x07/0x05 is at stage 8 -> outputs frozen, in_valid ignored during stall. Result appears 21 edges after acceptance, value unchanged (0x00BEEF).
- Reset mid-flight: 10 items in flight, then reset=1 for 1 cycle -> out_valid=0 and product=0 next cycle, and no pre-reset item ever emerges. A new item emerges 16 edges after its acceptance.

Source files
------------

// File: rtl/pipelinemul.sv
`default_nettype none
// ============================================================================
// Module   : pipelinemul
// Purpose  : Pipelined shift-add multiplier, product = quotient*divisor + remainder
// Revision : 1.0
// ============================================================================
module pipelinemul #(
    parameter int QUOTLEN    = 16,
    parameter int DIVISORLEN = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          stall,
    input  logic [QUOTLEN-1:0]            quotient,
    input  logic [DIVISORLEN-1:0]         divisor,
    input  logic [DIVISORLEN-1:0]         remainder,
    output logic                          out_valid,
    output logic [QUOTLEN+DIVISORLEN-1:0] product,
    output logic                          fits,
    output logic                          rem_ok
);

    localparam int PRODLEN = QUOTLEN + DIVISORLEN;

    logic [QUOTLEN-1:0]    r_valid;
    logic [QUOTLEN-1:0]    r_rem_ok;
    logic [PRODLEN-1:0]    r_acc  [QUOTLEN];
    logic [DIVISORLEN-1:0] r_div  [QUOTLEN];
    logic [QUOTLEN-1:0]    r_quot [QUOTLEN];
    logic [PRODLEN-1:0]    w_acc_next [QUOTLEN];

    // Stage s adds divisor<<s when quotient bit s is set; stage 0 seeds with the remainder.
    always_comb begin
        w_acc_next[0] = PRODLEN'(remainder) + (quotient[0] ? PRODLEN'(divisor) : '0);
        for (int s = 1; s < QUOTLEN; s++) begin
            w_acc_next[s] = r_acc[s-1]
                          + (r_quot[s-1][s] ? (PRODLEN'(r_div[s-1]) << s) : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= '0;
            r_rem_ok <= '0;
            for (int s = 0; s < QUOTLEN; s++) begin
                r_acc[s]  <= '0;
                r_div[s]  <= '0;
                r_quot[s] <= '0;
            end
        end else if (!stall) begin
            r_valid  <= {r_valid[QUOTLEN-2:0], in_valid};
            r_rem_ok <= {r_rem_ok[QUOTLEN-2:0], (remainder < divisor)};
            r_acc[0]  <= w_acc_next[0];
            r_div[0]  <= divisor;
            r_quot[0] <= quotient;
            for (int s = 1; s < QUOTLEN; s++) begin
                r_acc[s]  <= w_acc_next[s];
                r_div[s]  <= r_div[s-1];
                r_quot[s] <= r_quot[s-1];
            end
        end
    end

    assign out_valid = r_valid[QUOTLEN-1];
    assign product   = r_acc[QUOTLEN-1];
    assign rem_ok    = r_rem_ok[QUOTLEN-1];
    assign fits      = ~|product[PRODLEN-1:QUOTLEN];

endmodule
`default_nettype wire
